instr_prefetch_queue: RTL and testbench

//   Prefetch queue between the instruction memory and the PROCESSOR fetch port.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/instr_fifo.sv | 57 +++++
 rtl/instr_prefetch_queue.sv | 139 +++++++++++++
 tb/tb_instr_prefetch_queue.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

  localparam int unsigned PC_STEP = 4;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 16;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fifo.sv
// Synchronous FIFO of fetched instruction/PC pairs; flush beats push and pop.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   Push,
  input  fetch_entry_t           PushData,
  input  logic                   Pop,
  input  logic                   Flush,
  output fetch_entry_t           HeadData,
  output logic                   Full,
  output logic                   Empty,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic [CNT_W-1:0] countQ;
  logic             doPush;
  logic             doPop;

  assign Empty    = (countQ == '0);
  assign Full     = (countQ == CNT_W'(DEPTH));
  assign Count    = countQ;
  assign HeadData = mem[rdPtr];
  assign doPop    = Pop && !Empty;
  // A push into a full FIFO is accepted when the head leaves in the same cycle.
  assign doPush   = Push && (!Full || doPop);

  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      unique case ({doPush, doPop})
        2'b10:   countQ <= countQ + 1'b1;
        2'b01:   countQ <= countQ - 1'b1;
        default: countQ <= countQ;
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (doPush && !Flush && !Reset) mem[wrPtr] <= PushData;
  end

endmodule

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: req/ack memory fetch FSM feeding a small
// queue that the core drains via valid/ready; Redirect flushes and restarts.
module instr_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned       DEPTH    = 4,
  parameter int unsigned       ADDR_W   = PC_W,
  parameter int unsigned       DATA_W   = INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              MemReq,
  output logic [ADDR_W-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [DATA_W-1:0] MemData,
  output logic              FetchValid,
  output logic [DATA_W-1:0] FetchInstr,
  output logic [ADDR_W-1:0] FetchPC,
  input  logic              FetchReady,
  input  logic              Redirect,
  input  logic [ADDR_W-1:0] RedirectPC
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state;
  logic [ADDR_W-1:0] fetchPc;
  logic [ADDR_W-1:0] redirLatch;
  logic [ADDR_W-1:0] redirAligned;
  logic [ADDR_W-1:0] nextPc;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  countAfterPop;
  logic              full;
  logic              empty;
  logic              pop;
  logic              push;
  logic              spaceNow;
  logic              spaceAfterPush;
  fetch_entry_t      pushEntry;
  fetch_entry_t      headEntry;
  logic [DATA_W-1:0] lastInstr;
  logic [ADDR_W-1:0] lastPc;

  assign redirAligned   = RedirectPC & ~ADDR_W'(3);
  assign nextPc         = MemAddr + ADDR_W'(PC_STEP);
  assign pop            = FetchReady && !empty && !Redirect;
  assign push           = (state == REQ) && MemAck && !Redirect;
  assign pushEntry      = '{instr: MemData, pc: MemAddr};
  // Occupancy seen by the request logic is post-pop; the in-flight slot is the +1.
  assign countAfterPop  = count - CNT_W'(pop);
  assign spaceNow       = !full || pop;
  assign spaceAfterPush = (countAfterPop + CNT_W'(1)) < CNT_W'(DEPTH);

  instr_fifo #(
    .DEPTH(DEPTH)
  ) fifo (
    .Clock   (Clock),
    .Reset   (Reset),
    .Push    (push),
    .PushData(pushEntry),
    .Pop     (pop),
    .Flush   (Redirect),
    .HeadData(headEntry),
    .Full    (full),
    .Empty   (empty),
    .Count   (count)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      MemReq     <= 1'b0;
      MemAddr    <= RESET_PC;
      fetchPc    <= RESET_PC;
      redirLatch <= RESET_PC;
    end else begin
      unique case (state)
        IDLE: begin
          if (Redirect) begin
            fetchPc <= redirAligned;
          end else if (spaceNow) begin
            state   <= REQ;
            MemReq  <= 1'b1;
            MemAddr <= fetchPc;
          end
        end
        REQ: begin
          if (MemAck) begin
            if (Redirect) begin
              state   <= IDLE;
              MemReq  <= 1'b0;
              fetchPc <= redirAligned;
            end else if (spaceAfterPush) begin
              MemAddr <= nextPc;
              fetchPc <= nextPc;
            end else begin
              state   <= IDLE;
              MemReq  <= 1'b0;
              fetchPc <= nextPc;
            end
          end else if (Redirect) begin
            state      <= DRAIN;
            redirLatch <= redirAligned;
          end
        end
        DRAIN: begin
          if (MemAck) begin
            state   <= IDLE;
            MemReq  <= 1'b0;
            fetchPc <= Redirect ? redirAligned : redirLatch;
          end else if (Redirect) begin
            redirLatch <= redirAligned;
          end
        end
        default: begin
          state  <= IDLE;
          MemReq <= 1'b0;
        end
      endcase
    end
  end

  // Head outputs keep the last presented entry while the queue is empty.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      lastInstr <= '0;
      lastPc    <= '0;
    end else if (!empty) begin
      lastInstr <= headEntry.instr;
      lastPc    <= headEntry.pc;
    end
  end

  assign FetchValid = !empty;
  assign FetchInstr = empty ? lastInstr : headEntry.instr;
  assign FetchPC    = empty ? lastPc : headEntry.pc;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench: stimulus queues expected fetch addresses and delivered PCs;
// a monitor checks every new request and every consumed instruction.
module tb_instr_prefetch_queue;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        MemReq;
  logic [15:0] MemAddr;
  logic        MemAck;
  logic [31:0] MemData;
  logic        FetchValid;
  logic [31:0] FetchInstr;
  logic [15:0] FetchPC;
  logic        FetchReady = 1'b0;
  logic        Redirect = 1'b0;
  logic [15:0] RedirectPC = '0;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned ackDelay = 1;
  int unsigned acksLeft = 0;
  int unsigned ackCount = 0;
  logic [15:0] addrQ[$];
  logic [15:0] fetchQ[$];

  instr_prefetch_queue #(
    .DEPTH   (4),
    .ADDR_W  (16),
    .DATA_W  (32),
    .RESET_PC(16'h0000)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .MemReq    (MemReq),
    .MemAddr   (MemAddr),
    .MemAck    (MemAck),
    .MemData   (MemData),
    .FetchValid(FetchValid),
    .FetchInstr(FetchInstr),
    .FetchPC   (FetchPC),
    .FetchReady(FetchReady),
    .Redirect  (Redirect),
    .RedirectPC(RedirectPC)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] dataOf(input logic [15:0] pc);
    return {pc ^ 16'hA55A, pc};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: acks acksLeft requests, each ackDelay cycles after it appears.
  initial begin
    int unsigned waitCnt;
    waitCnt = 0;
    MemAck  = 1'b0;
    MemData = '0;
    forever begin
      @(posedge Clock);
      #2;
      MemAck = 1'b0;
      if (MemReq && acksLeft > 0) begin
        if (waitCnt >= ackDelay) begin
          MemAck  = 1'b1;
          MemData = dataOf(MemAddr);
          waitCnt = 0;
          acksLeft--;
        end else begin
          waitCnt++;
        end
      end else begin
        waitCnt = 0;
      end
    end
  end

  // Monitor: samples just before each rising edge.
  initial begin
    logic        outstanding;
    logic [15:0] heldAddr;
    logic [15:0] expPc;
    outstanding = 1'b0;
    heldAddr    = '0;
    forever begin
      @(negedge Clock);
      #4;
      if (Reset) begin
        outstanding = 1'b0;
      end else begin
        if (outstanding) begin
          check("req_held", 32'(MemReq), 1);
          if (MemReq) check("addr_held", 32'(MemAddr), 32'(heldAddr));
        end else if (MemReq) begin
          check("req_expected", 32'(addrQ.size() > 0), 1);
          if (addrQ.size() > 0) check("req_addr", 32'(MemAddr), 32'(addrQ.pop_front()));
          check("addr_align", 32'(MemAddr[1:0]), 0);
          heldAddr = MemAddr;
        end
        if (MemReq && MemAck) ackCount++;
        if (FetchValid && FetchReady && !Redirect) begin
          check("fetch_expected", 32'(fetchQ.size() > 0), 1);
          if (fetchQ.size() > 0) begin
            expPc = fetchQ.pop_front();
            check("fetch_pc", 32'(FetchPC), 32'(expPc));
            check("fetch_instr", FetchInstr, dataOf(expPc));
          end
        end
        outstanding = MemReq && !MemAck;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic waitCycles(input int unsigned n);
    repeat (n) @(negedge Clock);
  endtask

  task automatic waitAck(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge Clock);
      #2;
      seen = MemAck;
    end
    check(name, 32'(seen), 1);
  endtask

  // Leaves Reset high at a falling edge; the caller releases it.
  task automatic doReset();
    acksLeft   = 0;
    Redirect   = 1'b0;
    FetchReady = 1'b0;
    @(negedge Clock);
    Reset = 1'b1;
    @(negedge Clock);
    #2;
    check("rst_memreq", 32'(MemReq), 0);
    check("rst_memaddr", 32'(MemAddr), 0);
    check("rst_valid", 32'(FetchValid), 0);
    check("rst_instr", FetchInstr, 0);
    check("rst_pc", 32'(FetchPC), 0);
    addrQ.delete();
    fetchQ.delete();
    ackCount = 0;
    @(negedge Clock);
  endtask

  task automatic endTest();
    check("leftover_addr", 32'(addrQ.size()), 0);
    check("leftover_fetch", 32'(fetchQ.size()), 0);
  endtask

  initial begin
    // 1: continuous fetch with one-cycle ack latency
    doReset();
    ackDelay = 1; acksLeft = 3; FetchReady = 1'b1;
    addrQ = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
    fetchQ = '{16'h0000, 16'h0004, 16'h0008};
    Reset = 1'b0;
    @(negedge Clock);
    #2;
    check("t1_first_req", 32'(MemReq), 1);
    check("t1_first_addr", 32'(MemAddr), 'h0);
    waitAck("t1_ack_seen");
    check("t1_valid_before", 32'(FetchValid), 0);
    @(negedge Clock);
    #2;
    check("t1_valid_after", 32'(FetchValid), 1);
    check("t1_first_pc", 32'(FetchPC), 'h0);
    waitCycles(12);
    endTest();

    // 2: core stalled, queue fills to DEPTH then one pop reopens fetch
    doReset();
    ackDelay = 1; acksLeft = 5; FetchReady = 1'b0;
    addrQ = '{16'h0000, 16'h0004, 16'h0008, 16'h000C, 16'h0010};
    fetchQ = '{16'h0000};
    Reset = 1'b0;
    waitCycles(14);
    #2;
    check("t2_acks_full", ackCount, 4);
    check("t2_req_stall", 32'(MemReq), 0);
    check("t2_valid_full", 32'(FetchValid), 1);
    @(negedge Clock);
    FetchReady = 1'b1;
    #2;
    check("t2_stall_still", 32'(MemReq), 0);
    @(negedge Clock);
    FetchReady = 1'b0;
    #2;
    check("t2_repop_req", 32'(MemReq), 1);
    check("t2_repop_addr", 32'(MemAddr), 'h10);
    waitCycles(6);
    #2;
    check("t2_acks_total", ackCount, 5);
    check("t2_req_refull", 32'(MemReq), 0);
    endTest();

    // 3: redirect while the request waits for a slow ack
    doReset();
    ackDelay = 3; acksLeft = 2; FetchReady = 1'b1;
    addrQ = '{16'h0000, 16'h0100, 16'h0104};
    fetchQ = '{16'h0100};
    Reset = 1'b0;
    @(negedge Clock);
    @(negedge Clock);
    Redirect = 1'b1; RedirectPC = 16'h0101;
    @(negedge Clock);
    Redirect = 1'b0;
    #2;
    check("t3_hold_req", 32'(MemReq), 1);
    check("t3_hold_addr", 32'(MemAddr), 'h0);
    waitCycles(16);
    endTest();

    // 4: redirect in the same cycle as the ack
    doReset();
    ackDelay = 1; acksLeft = 3; FetchReady = 1'b1;
    addrQ = '{16'h0000, 16'h0200, 16'h0204, 16'h0208};
    fetchQ = '{16'h0200, 16'h0204};
    Reset = 1'b0;
    waitAck("t4_ack_seen");
    Redirect = 1'b1; RedirectPC = 16'h0200;
    @(negedge Clock);
    Redirect = 1'b0;
    #2;
    check("t4_valid_drop", 32'(FetchValid), 0);
    check("t4_req_idle", 32'(MemReq), 0);
    @(negedge Clock);
    #2;
    check("t4_redir_req", 32'(MemReq), 1);
    check("t4_redir_addr", 32'(MemAddr), 'h200);
    waitCycles(10);
    endTest();

    // 5: fetch address wraps past the top of the address space
    doReset();
    ackDelay = 1; acksLeft = 0; FetchReady = 1'b1;
    addrQ = '{16'h0000, 16'hFFFC, 16'h0000, 16'h0004, 16'h0008};
    fetchQ = '{16'hFFFC, 16'h0000, 16'h0004};
    Reset = 1'b0;
    @(negedge Clock);
    Redirect = 1'b1; RedirectPC = 16'hFFFC;
    @(negedge Clock);
    Redirect = 1'b0; acksLeft = 4;
    waitCycles(16);
    endTest();

    // 6: reset with entries queued and a request outstanding
    doReset();
    ackDelay = 1; acksLeft = 2; FetchReady = 1'b0;
    addrQ = '{16'h0000, 16'h0004, 16'h0008};
    Reset = 1'b0;
    waitCycles(8);
    #2;
    check("t6_pre_valid", 32'(FetchValid), 1);
    check("t6_pre_pc", 32'(FetchPC), 'h0);
    check("t6_pre_req", 32'(MemReq), 1);
    check("t6_pre_addr", 32'(MemAddr), 'h8);
    endTest();
    doReset();
    acksLeft = 1; FetchReady = 1'b1;
    addrQ = '{16'h0000, 16'h0004};
    fetchQ = '{16'h0000};
    Reset = 1'b0;
    waitCycles(10);
    endTest();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
